face_box_multi: RTL and testbench



---
 rtl/face_box_multi.sv | 238 +++++++++++++++++++++++
 tb/tb_face_box_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/face_box_multi.sv
// Multi-zone skin bounding-box tracker: accumulates one box per vertical strip
// from the mask stream and overlays qualified box borders onto live RGB565 video.
module face_box_multi #(
  parameter int          COL       = 1280,
  parameter int          ROW       = 720,
  parameter int          NUM_ZONES = 4,
  parameter int          MIN_PIX   = 64,
  parameter int          THICK     = 2,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic        video_pclk,
  input  logic        rst_n,
  input  logic        mask_valid,
  input  logic        mask_sof,
  input  logic        mask_bit,
  input  logic        video_valid,
  input  logic        video_sof,
  input  logic [15:0] video_data,
  input  logic        draw_en,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        frame_done,
  output logic [3:0]  face_cnt
);

  localparam int          ZW     = COL / NUM_ZONES;
  localparam logic [15:0] COL_M1 = 16'(COL - 1);
  localparam logic [15:0] ROW_M1 = 16'(ROW - 1);
  localparam logic [15:0] ZW_M1  = 16'(ZW - 1);
  localparam logic [15:0] THK    = 16'(THICK);
  localparam logic [19:0] MIN_C  = 20'(MIN_PIX);

  function automatic logic [15:0] zone_lo(input int z);
    return 16'(z * ZW);
  endfunction

  function automatic logic [15:0] zone_hi(input int z);
    return 16'((z + 1) * ZW - 1);
  endfunction

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  function automatic logic [3:0] popcnt(input logic [NUM_ZONES-1:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < NUM_ZONES; i++) s = s + 4'(v[i]);
    return s;
  endfunction

  // Raster step returning {x, y, x-within-zone, zone}; zone advances on strip boundaries.
  function automatic logic [51:0] step_pos(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] zx, input logic [3:0] z);
    logic [15:0] nx, ny, nzx;
    logic [3:0]  nz;
    if (x == COL_M1) begin
      nx  = '0;
      nzx = '0;
      nz  = '0;
      ny  = (y == ROW_M1) ? 16'd0 : y + 16'd1;
    end else begin
      nx = x + 16'd1;
      ny = y;
      if (zx == ZW_M1) begin
        nzx = '0;
        nz  = z + 4'd1;
      end else begin
        nzx = zx + 16'd1;
        nz  = z;
      end
    end
    return {nx, ny, nzx, nz};
  endfunction

  logic [15:0] mx_q, mx_d, my_q, my_d, mzx_q, mzx_d;
  logic [3:0]  mz_q, mz_d;
  logic [15:0] vx_q, vx_d, vy_q, vy_d, vzx_q, vzx_d;
  logic [3:0]  vz_q, vz_d;
  logic [15:0] mcx, mcy, mczx, vcx, vcy, vczx;
  logic [3:0]  mcz, vcz;
  logic        eof, border;

  logic [15:0] acc_up_q [NUM_ZONES], acc_up_d [NUM_ZONES];
  logic [15:0] acc_dn_q [NUM_ZONES], acc_dn_d [NUM_ZONES];
  logic [15:0] acc_lf_q [NUM_ZONES], acc_lf_d [NUM_ZONES];
  logic [15:0] acc_rt_q [NUM_ZONES], acc_rt_d [NUM_ZONES];
  logic [19:0] acc_cnt_q[NUM_ZONES], acc_cnt_d[NUM_ZONES];
  logic [15:0] box_up_q [NUM_ZONES], box_up_d [NUM_ZONES];
  logic [15:0] box_dn_q [NUM_ZONES], box_dn_d [NUM_ZONES];
  logic [15:0] box_lf_q [NUM_ZONES], box_lf_d [NUM_ZONES];
  logic [15:0] box_rt_q [NUM_ZONES], box_rt_d [NUM_ZONES];
  logic [NUM_ZONES-1:0] box_vld_q, box_vld_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  face_cnt_q, face_cnt_d;

  logic        vld_p1_q, vld_p1_d, brd_p1_q, brd_p1_d;
  logic [15:0] data_p1_q, data_p1_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;

  // A sof pixel is (0,0) regardless of where the counters were.
  always_comb begin
    mcx  = mask_sof ? 16'd0 : mx_q;
    mcy  = mask_sof ? 16'd0 : my_q;
    mczx = mask_sof ? 16'd0 : mzx_q;
    mcz  = mask_sof ? 4'd0  : mz_q;
    {mx_d, my_d, mzx_d, mz_d} = {mx_q, my_q, mzx_q, mz_q};
    if (mask_valid) {mx_d, my_d, mzx_d, mz_d} = step_pos(mcx, mcy, mczx, mcz);
    eof = mask_valid && (mcx == COL_M1) && (mcy == ROW_M1);
  end

  // End-of-frame latches the accumulators including the final pixel in the same edge.
  always_comb begin
    box_vld_d    = box_vld_q;
    frame_done_d = eof;
    face_cnt_d   = face_cnt_q;
    for (int z = 0; z < NUM_ZONES; z++) begin
      box_up_d[z] = box_up_q[z];
      box_dn_d[z] = box_dn_q[z];
      box_lf_d[z] = box_lf_q[z];
      box_rt_d[z] = box_rt_q[z];
      if (mask_valid && mask_sof) begin
        acc_up_d[z]  = ROW_M1;
        acc_dn_d[z]  = '0;
        acc_lf_d[z]  = zone_hi(z);
        acc_rt_d[z]  = zone_lo(z);
        acc_cnt_d[z] = '0;
      end else begin
        acc_up_d[z]  = acc_up_q[z];
        acc_dn_d[z]  = acc_dn_q[z];
        acc_lf_d[z]  = acc_lf_q[z];
        acc_rt_d[z]  = acc_rt_q[z];
        acc_cnt_d[z] = acc_cnt_q[z];
      end
      if (mask_valid && mask_bit && (mcz == 4'(z))) begin
        if (mcy < acc_up_d[z]) acc_up_d[z] = mcy;
        if (mcy > acc_dn_d[z]) acc_dn_d[z] = mcy;
        if (mcx < acc_lf_d[z]) acc_lf_d[z] = mcx;
        if (mcx > acc_rt_d[z]) acc_rt_d[z] = mcx;
        acc_cnt_d[z] = sat_inc(acc_cnt_d[z]);
      end
      if (eof) begin
        box_up_d[z]  = acc_up_d[z];
        box_dn_d[z]  = acc_dn_d[z];
        box_lf_d[z]  = acc_lf_d[z];
        box_rt_d[z]  = acc_rt_d[z];
        box_vld_d[z] = (acc_cnt_d[z] >= MIN_C);
        acc_up_d[z]  = ROW_M1;
        acc_dn_d[z]  = '0;
        acc_lf_d[z]  = zone_hi(z);
        acc_rt_d[z]  = zone_lo(z);
        acc_cnt_d[z] = '0;
      end
    end
    if (eof) face_cnt_d = popcnt(box_vld_d);
  end

  // Stage 1: border test against the display set; narrow boxes fill solid naturally.
  always_comb begin
    vcx  = video_sof ? 16'd0 : vx_q;
    vcy  = video_sof ? 16'd0 : vy_q;
    vczx = video_sof ? 16'd0 : vzx_q;
    vcz  = video_sof ? 4'd0  : vz_q;
    {vx_d, vy_d, vzx_d, vz_d} = {vx_q, vy_q, vzx_q, vz_q};
    if (video_valid) {vx_d, vy_d, vzx_d, vz_d} = step_pos(vcx, vcy, vczx, vcz);
    border = 1'b0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      if (box_vld_q[z] && vcx >= box_lf_q[z] && vcx <= box_rt_q[z] &&
          vcy >= box_up_q[z] && vcy <= box_dn_q[z]) begin
        if ((vcx - box_lf_q[z]) < THK || (box_rt_q[z] - vcx) < THK ||
            (vcy - box_up_q[z]) < THK || (box_dn_q[z] - vcy) < THK)
          border = 1'b1;
      end
    end
    vld_p1_d  = video_valid;
    data_p1_d = video_valid ? video_data : data_p1_q;
    brd_p1_d  = video_valid ? border : brd_p1_q;
    // Stage 2: overlay
    out_valid_d = vld_p1_q;
    out_data_d  = out_data_q;
    if (vld_p1_q) out_data_d = (brd_p1_q && draw_en) ? BOX_COLOR : data_p1_q;
  end

  always_ff @(posedge video_pclk or negedge rst_n) begin
    if (!rst_n) begin
      {mx_q, my_q, mzx_q, mz_q} <= '0;
      {vx_q, vy_q, vzx_q, vz_q} <= '0;
      for (int z = 0; z < NUM_ZONES; z++) begin
        acc_up_q[z]  <= ROW_M1;
        acc_dn_q[z]  <= '0;
        acc_lf_q[z]  <= zone_hi(z);
        acc_rt_q[z]  <= zone_lo(z);
        acc_cnt_q[z] <= '0;
        box_up_q[z]  <= '0;
        box_dn_q[z]  <= '0;
        box_lf_q[z]  <= '0;
        box_rt_q[z]  <= '0;
      end
      box_vld_q    <= '0;
      frame_done_q <= 1'b0;
      face_cnt_q   <= '0;
      vld_p1_q     <= 1'b0;
      brd_p1_q     <= 1'b0;
      data_p1_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      {mx_q, my_q, mzx_q, mz_q} <= {mx_d, my_d, mzx_d, mz_d};
      {vx_q, vy_q, vzx_q, vz_q} <= {vx_d, vy_d, vzx_d, vz_d};
      for (int z = 0; z < NUM_ZONES; z++) begin
        acc_up_q[z]  <= acc_up_d[z];
        acc_dn_q[z]  <= acc_dn_d[z];
        acc_lf_q[z]  <= acc_lf_d[z];
        acc_rt_q[z]  <= acc_rt_d[z];
        acc_cnt_q[z] <= acc_cnt_d[z];
        box_up_q[z]  <= box_up_d[z];
        box_dn_q[z]  <= box_dn_d[z];
        box_lf_q[z]  <= box_lf_d[z];
        box_rt_q[z]  <= box_rt_d[z];
      end
      box_vld_q    <= box_vld_d;
      frame_done_q <= frame_done_d;
      face_cnt_q   <= face_cnt_d;
      vld_p1_q     <= vld_p1_d;
      brd_p1_q     <= brd_p1_d;
      data_p1_q    <= data_p1_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign face_cnt   = face_cnt_q;

endmodule

// File: tb/tb_face_box_multi.sv
// Directed + randomized bench for face_box_multi: two instances (THICK=1 and THICK=2)
// checked against an image-level box model and a two-cycle video pipeline model.
module tb_face_box_multi;
  localparam int COL = 16, ROW = 8, NZ = 2, MINP = 4, NPIX = COL * ROW, ZW = COL / NZ;

  logic        video_pclk, rst_n;
  logic        mask_valid, mask_sof, mask_bit;
  logic        video_valid, video_sof, draw_en;
  logic [15:0] video_data;
  logic        out_valid1, out_valid2, frame_done1, frame_done2;
  logic [15:0] out_data1, out_data2;
  logic [3:0]  face_cnt1, face_cnt2;

  face_box_multi #(.COL(COL), .ROW(ROW), .NUM_ZONES(NZ), .MIN_PIX(MINP), .THICK(1),
                   .BOX_COLOR(16'hF800)) u_dut1 (
    .video_pclk(video_pclk), .rst_n(rst_n), .mask_valid(mask_valid), .mask_sof(mask_sof),
    .mask_bit(mask_bit), .video_valid(video_valid), .video_sof(video_sof),
    .video_data(video_data), .draw_en(draw_en), .out_valid(out_valid1),
    .out_data(out_data1), .frame_done(frame_done1), .face_cnt(face_cnt1));

  face_box_multi #(.COL(COL), .ROW(ROW), .NUM_ZONES(NZ), .MIN_PIX(MINP), .THICK(2),
                   .BOX_COLOR(16'hF800)) u_dut2 (
    .video_pclk(video_pclk), .rst_n(rst_n), .mask_valid(mask_valid), .mask_sof(mask_sof),
    .mask_bit(mask_bit), .video_valid(video_valid), .video_sof(video_sof),
    .video_data(video_data), .draw_en(draw_en), .out_valid(out_valid2),
    .out_data(out_data2), .frame_done(frame_done2), .face_cnt(face_cnt2));

  initial video_pclk = 1'b0;
  always #5 video_pclk = ~video_pclk;

  int n_cmp = 0, n_err = 0;

  bit img[NPIX];
  bit acc_img[NPIX];
  bit m_bv[NZ];
  int m_l[NZ], m_r[NZ], m_u[NZ], m_d[NZ];
  int m_fc;

  bit          cur_v, pv_0, pv_1;
  logic [15:0] cur_e1, cur_e2, pe1_0, pe1_1, pe2_0, pe2_1, eo1, eo2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Boxes from the pixels accumulated since the last frame start.
  task automatic latch_model();
    m_fc = 0;
    for (int z = 0; z < NZ; z++) begin
      int cnt, l, r, u, d;
      cnt = 0; l = COL; r = -1; u = ROW; d = -1;
      for (int y = 0; y < ROW; y++)
        for (int x = z * ZW; x < (z + 1) * ZW; x++)
          if (acc_img[y * COL + x]) begin
            cnt++;
            if (x < l) l = x;
            if (x > r) r = x;
            if (y < u) u = y;
            if (y > d) d = y;
          end
      m_bv[z] = (cnt >= MINP);
      m_l[z] = l; m_r[z] = r; m_u[z] = u; m_d[z] = d;
      if (m_bv[z]) m_fc++;
    end
  endtask

  function automatic bit bord(input int x, input int y, input int th);
    bit hit;
    hit = 0;
    for (int z = 0; z < NZ; z++) begin
      if (m_bv[z] && x >= m_l[z] && x <= m_r[z] && y >= m_u[z] && y <= m_d[z]) begin
        int dmin;
        dmin = x - m_l[z];
        if (m_r[z] - x < dmin) dmin = m_r[z] - x;
        if (y - m_u[z] < dmin) dmin = y - m_u[z];
        if (m_d[z] - y < dmin) dmin = m_d[z] - y;
        if (dmin < th) hit = 1;
      end
    end
    return hit;
  endfunction

  task automatic tick(input bit exp_fd);
    @(posedge video_pclk); #1;
    pv_1 = pv_0; pe1_1 = pe1_0; pe2_1 = pe2_0;
    pv_0 = cur_v; pe1_0 = cur_e1; pe2_0 = cur_e2;
    if (pv_1) begin eo1 = pe1_1; eo2 = pe2_1; end
    chk("out_valid1", 16'(out_valid1), 16'(pv_1));
    chk("out_valid2", 16'(out_valid2), 16'(pv_1));
    chk("out_data1", out_data1, eo1);
    chk("out_data2", out_data2, eo2);
    chk("frame_done1", 16'(frame_done1), 16'(exp_fd));
    chk("frame_done2", 16'(frame_done2), 16'(exp_fd));
    chk("face_cnt1", 16'(face_cnt1), 16'(m_fc));
    chk("face_cnt2", 16'(face_cnt2), 16'(m_fc));
  endtask

  task automatic mask_run(input int from, input int to, input bit sof_first);
    bit eof;
    cur_v = 0;
    for (int i = from; i <= to; i++) begin
      if ($urandom_range(3) == 0) begin
        mask_valid = 0; mask_sof = 0; mask_bit = 0;
        tick(0);
      end
      mask_valid = 1;
      mask_sof   = sof_first && (i == from);
      mask_bit   = img[i];
      if (mask_sof) for (int j = 0; j < NPIX; j++) acc_img[j] = 0;
      acc_img[i] = img[i];
      eof = (i == NPIX - 1);
      if (eof) begin
        latch_model();
        for (int j = 0; j < NPIX; j++) acc_img[j] = 0;
      end
      tick(eof);
    end
    mask_valid = 0; mask_sof = 0; mask_bit = 0;
  endtask

  task automatic video_run(input int from, input int to, input bit sof_first, input bit de);
    draw_en = de;
    for (int i = from; i <= to; i++) begin
      if ($urandom_range(3) == 0) begin
        video_valid = 0; video_sof = 0; cur_v = 0;
        tick(0);
      end
      video_valid = 1;
      video_sof   = sof_first && (i == from);
      video_data  = 16'($urandom);
      cur_v  = 1;
      cur_e1 = (de && bord(i % COL, i / COL, 1)) ? 16'hF800 : video_data;
      cur_e2 = (de && bord(i % COL, i / COL, 2)) ? 16'hF800 : video_data;
      tick(0);
    end
    video_valid = 0; video_sof = 0; cur_v = 0;
    repeat (3) tick(0);
  endtask

  task automatic clr_img();
    for (int i = 0; i < NPIX; i++) img[i] = 0;
  endtask

  task automatic box_img(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y * COL + x] = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 16'({out_valid1, out_valid2}), 16'd0);
    chk({tag, "_out_data1"}, out_data1, 16'd0);
    chk({tag, "_out_data2"}, out_data2, 16'd0);
    chk({tag, "_frame_done"}, 16'({frame_done1, frame_done2}), 16'd0);
    chk({tag, "_face_cnt1"}, 16'(face_cnt1), 16'd0);
    chk({tag, "_face_cnt2"}, 16'(face_cnt2), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; mask_valid = 0; mask_sof = 0; mask_bit = 0;
    video_valid = 0; video_sof = 0; video_data = '0; draw_en = 0;
    cur_v = 0; pv_0 = 0; pv_1 = 0;
    cur_e1 = '0; cur_e2 = '0; pe1_0 = '0; pe1_1 = '0; pe2_0 = '0; pe2_1 = '0; eo1 = '0; eo2 = '0;
    m_fc = 0;
    for (int z = 0; z < NZ; z++) begin m_bv[z] = 0; m_l[z] = 0; m_r[z] = 0; m_u[z] = 0; m_d[z] = 0; end
    for (int i = 0; i < NPIX; i++) acc_img[i] = 0;
    clr_img();
    repeat (3) @(posedge video_pclk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    tick(0);

    // Single box in zone 0
    clr_img(); box_img(2, 5, 1, 4);
    mask_run(0, NPIX - 1, 1);
    video_run(0, NPIX - 1, 1, 1);

    // Zone 0 below MIN_PIX, zone 1 qualifies
    clr_img(); box_img(9, 11, 5, 6);
    img[0 * COL + $urandom_range(7)] = 1;
    img[3 * COL + $urandom_range(7)] = 1;
    img[6 * COL + $urandom_range(7)] = 1;
    mask_run(0, NPIX - 1, 1);
    video_run(0, NPIX - 1, 1, 1);

    // Final pixel of the frame is counted
    clr_img();
    img[7 * COL + 15] = 1; img[3 * COL + 12] = 1; img[6 * COL + 9] = 1; img[0 * COL + 14] = 1;
    mask_run(0, NPIX - 1, 1);
    video_run(0, NPIX - 1, 1, 1);

    // Random masks of varying density
    for (int f = 0; f < 3; f++) begin
      int dens;
      dens = $urandom_range(5, 40);
      for (int i = 0; i < NPIX; i++) img[i] = ($urandom_range(99) < dens);
      mask_run(0, NPIX - 1, 1);
      video_run(0, NPIX - 1, 1, 1);
    end

    // 3x3 box: solid on THICK=2, then overlay disabled
    clr_img(); box_img(9, 11, 2, 4);
    mask_run(0, NPIX - 1, 1);
    video_run(0, NPIX - 1, 1, 1);
    video_run(0, NPIX - 1, 1, 0);

    // Mid-frame sof at pixel 40 discards the partial frame; stale boxes keep drawing
    for (int i = 0; i < NPIX; i++) img[i] = ($urandom_range(99) < 50);
    mask_run(0, 39, 1);
    clr_img(); box_img(1, 4, 4, 7);
    mask_run(0, 0, 1);
    video_run(0, NPIX - 1, 1, 1);
    mask_run(1, NPIX - 1, 0);
    video_run(0, NPIX - 1, 1, 1);

    // Reset mid-frame on both streams
    for (int i = 0; i < NPIX; i++) img[i] = ($urandom_range(99) < 60);
    mask_run(0, 60, 1);
    video_run(0, 50, 1, 1);
    @(posedge video_pclk); #2;
    rst_n = 0;
    #1;
    chk_zero("midreset");
    @(posedge video_pclk); #2;
    rst_n = 1;
    pv_0 = 0; pv_1 = 0; eo1 = '0; eo2 = '0; m_fc = 0;
    for (int z = 0; z < NZ; z++) m_bv[z] = 0;
    for (int i = 0; i < NPIX; i++) acc_img[i] = 0;
    video_run(0, NPIX - 1, 0, 1);
    clr_img(); box_img(10, 14, 0, 3);
    mask_run(0, NPIX - 1, 0);
    video_run(0, NPIX - 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
